// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush that inserts bubbles, and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 111,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_valid_reg;
    logic [CTRL_W-1:0] out_ctrl_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              stalled;
    logic              in_xfer;

    assign stalled   = out_valid_reg && !out_ready;
    assign in_xfer   = in_valid && in_ready;

    assign out_valid = out_valid_reg;
    assign out_ctrl  = out_ctrl_reg;
    assign out_data  = out_data_reg;
    assign stall_cnt = stall_cnt_reg;

    // Counts stalled edges regardless of flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (stalled && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid_reg;
            logic [CTRL_W-1:0] skid_ctrl_reg;
            logic [DATA_W-1:0] skid_data_reg;

            // Ready depends only on held state, so out_ready never reaches in_ready.
            assign in_ready = !skid_valid_reg;
            assign count    = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg};

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid_reg  <= 1'b0;
                    out_ctrl_reg   <= '0;
                    out_data_reg   <= '0;
                    skid_valid_reg <= 1'b0;
                    skid_ctrl_reg  <= '0;
                    skid_data_reg  <= '0;
                end else if (flush) begin
                    out_valid_reg  <= 1'b0;
                    out_ctrl_reg   <= '0;
                    skid_valid_reg <= 1'b0;
                end else if (!stalled) begin
                    // in_ready is low while the skid is full, so no input arrives in that branch.
                    if (skid_valid_reg) begin
                        out_valid_reg  <= 1'b1;
                        out_ctrl_reg   <= skid_ctrl_reg;
                        out_data_reg   <= skid_data_reg;
                        skid_valid_reg <= 1'b0;
                    end else if (in_xfer) begin
                        out_valid_reg <= 1'b1;
                        out_ctrl_reg  <= in_ctrl;
                        out_data_reg  <= in_data;
                    end else begin
                        out_valid_reg <= 1'b0;
                        out_ctrl_reg  <= '0;
                    end
                end else if (in_xfer) begin
                    skid_valid_reg <= 1'b1;
                    skid_ctrl_reg  <= in_ctrl;
                    skid_data_reg  <= in_data;
                end
            end
        end else begin : g_noskid
            assign in_ready = out_ready || !out_valid_reg;
            assign count    = {1'b0, out_valid_reg};

            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid_reg <= 1'b0;
                    out_ctrl_reg  <= '0;
                    out_data_reg  <= '0;
                end else if (flush) begin
                    out_valid_reg <= 1'b0;
                    out_ctrl_reg  <= '0;
                end else if (in_xfer) begin
                    out_valid_reg <= 1'b1;
                    out_ctrl_reg  <= in_ctrl;
                    out_data_reg  <= in_data;
                end else if (out_valid_reg && out_ready) begin
                    out_valid_reg <= 1'b0;
                    out_ctrl_reg  <= '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid-buffered stage (3-bit stall counter) and a single-entry stage side by side,
// comparing both against queue-based FIFO models every cycle.
module tb_pipe_stage_reg;
    localparam int CW = 12;
    localparam int DW = 111;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic a_fl, a_iv, a_ordy, b_fl, b_iv, b_ordy;
    logic [CW-1:0] a_c, b_c;
    logic [DW-1:0] a_d, b_d;
    logic a_ir, a_ov, b_ir, b_ov;
    logic [CW-1:0] a_oc, b_oc;
    logic [DW-1:0] a_od, b_od;
    logic [1:0] a_cnt, b_cnt;
    logic [2:0] a_stall;
    logic [15:0] b_stall;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .flush(a_fl),
        .in_valid(a_iv), .in_ready(a_ir), .in_ctrl(a_c), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_ordy), .out_ctrl(a_oc), .out_data(a_od),
        .count(a_cnt), .stall_cnt(a_stall));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(b_fl),
        .in_valid(b_iv), .in_ready(b_ir), .in_ctrl(b_c), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_ordy), .out_ctrl(b_oc), .out_data(b_od),
        .count(b_cnt), .stall_cnt(b_stall));

    // Reference: a FIFO of capacity 2 (skid) or 1 (no skid) whose head is the output entry.
    ent_t qa[$];
    ent_t qb[$];
    int unsigned sa, sb;
    logic [DW-1:0] a_last, b_last;
    bit a_known, b_known;
    bit started = 0;
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic check_all();
        chk("a_in_ready", a_ir, qa.size() < 2);
        chk("a_out_valid", a_ov, qa.size() > 0);
        chk("a_out_ctrl", a_oc, qa.size() > 0 ? qa[0].c : '0);
        if (a_known) chk("a_out_data", a_od, a_last);
        chk("a_count", a_cnt, qa.size());
        chk("a_stall_cnt", a_stall, sa);
        chk("b_in_ready", b_ir, (qb.size() == 0) || b_ordy);
        chk("b_out_valid", b_ov, qb.size() > 0);
        chk("b_out_ctrl", b_oc, qb.size() > 0 ? qb[0].c : '0);
        if (b_known) chk("b_out_data", b_od, b_last);
        chk("b_count", b_cnt, qb.size());
        chk("b_stall_cnt", b_stall, sb);
    endtask

    task automatic update_model();
        bit ix, ox;
        if (reset) begin
            qa.delete(); qb.delete();
            sa = 0; sb = 0;
            a_last = '0; b_last = '0;
            a_known = 1; b_known = 1;
        end else begin
            if (qa.size() > 0 && !a_ordy && sa < 7) sa++;
            ix = a_iv && (qa.size() < 2);
            ox = (qa.size() > 0) && a_ordy;
            if (a_fl) begin
                qa.delete();
                a_known = 0;
            end else begin
                if (ox) void'(qa.pop_front());
                if (ix) qa.push_back({a_c, a_d});
            end
            if (qa.size() > 0) begin a_last = qa[0].d; a_known = 1; end

            if (qb.size() > 0 && !b_ordy && sb < 65535) sb++;
            ix = b_iv && ((qb.size() == 0) || b_ordy);
            ox = (qb.size() > 0) && b_ordy;
            if (b_fl) begin
                qb.delete();
                b_known = 0;
            end else begin
                if (ox) void'(qb.pop_front());
                if (ix) qb.push_back({b_c, b_d});
            end
            if (qb.size() > 0) begin b_last = qb[0].d; b_known = 1; end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (started) check_all();
        @(posedge clk);
        update_model();
        started = 1;
        #1;
    endtask

    task automatic new_a(input logic iv);
        a_iv = iv; a_c = CW'($urandom); a_d = rnd_data();
    endtask

    initial begin
        // Reset held two cycles with valid inputs present
        reset = 1; a_fl = 0; b_fl = 0; a_ordy = 1; b_ordy = 1;
        a_iv = 1; b_iv = 1; a_c = 12'h801; b_c = 12'h801; a_d = rnd_data(); b_d = rnd_data();
        cycle(); cycle();
        reset = 0; b_iv = 0;

        // Pass-through: A (ctrl 801), B, C back to back
        a_c = 12'h801; a_d = rnd_data(); cycle();
        new_a(1); cycle();
        new_a(1); cycle();
        a_iv = 0; cycle(); cycle();

        // Backpressure: A held, B into skid, C blocked, then drain
        a_ordy = 0; new_a(1); cycle();
        new_a(1); cycle();
        new_a(1); cycle(); cycle();
        a_ordy = 1; cycle(); cycle();
        a_iv = 0; cycle(); cycle();

        // Flush while stalled with two entries and a pending input
        a_ordy = 0; new_a(1); cycle(); new_a(1); cycle();
        new_a(1); a_fl = 1; cycle();
        a_fl = 0; a_iv = 0; a_ordy = 1; cycle(); cycle();

        // Stall counter saturation with a 3-bit counter
        a_ordy = 0; new_a(1); cycle();
        a_iv = 0;
        for (int i = 0; i < 10; i++) cycle();
        a_ordy = 1; cycle(); cycle();

        // Single-entry stage with out_ready toggling and in_valid held high
        b_iv = 1;
        for (int i = 0; i < 12; i++) begin
            b_ordy = (i % 2 == 0);
            b_c = CW'($urandom); b_d = rnd_data();
            cycle();
        end
        b_iv = 0; b_ordy = 1; cycle(); cycle();

        // Randomized traffic on both stages
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 249) == 0);
            a_fl   = ($urandom_range(0, 31) == 0);
            b_fl   = ($urandom_range(0, 31) == 0);
            a_ordy = $urandom_range(0, 2) != 0;
            b_ordy = $urandom_range(0, 1) != 0;
            new_a($urandom_range(0, 3) != 0);
            b_iv = $urandom_range(0, 3) != 0;
            b_c = CW'($urandom); b_d = rnd_data();
            cycle();
        end
        reset = 0; a_fl = 0; b_fl = 0; a_iv = 0; b_iv = 0; a_ordy = 1; b_ordy = 1;
        cycle(); cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
